// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// funct codes, ALU operations and the per-state control bundle.
package mips_pkg;

   localparam int unsigned OP_W     = 6;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned ALUC_W   = 3;
   localparam int unsigned ALUOP_W  = 2;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

   localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

   // Datapath control bundle produced by each state
   typedef struct packed {
      logic               iord;
      logic               mem_write;
      logic               ir_write;
      logic               pc_write;
      logic               branch;
      logic               reg_dst;
      logic               mem_to_reg;
      logic               reg_write;
      logic               alu_src_a;
      logic [SEL_W-1:0]   alu_src_b;
      logic [SEL_W-1:0]   pc_src;
      logic [ALUOP_W-1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the control unit's alu_op plus the R-type funct field to the ALU
// operation code.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            // Unknown funct codes fall back to ADD and still write back
            case (funct)
               FN_ADD:  alu_control = ALU_ADD;
               FN_SUB:  alu_control = ALU_SUB;
               FN_AND:  alu_control = ALU_AND;
               FN_OR:   alu_control = ALU_OR;
               FN_SLT:  alu_control = ALU_SLT;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives datapath selects.
module multicycle_control_unit
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero_flag,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_en,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_control
);

   state_t state;
   state_t state_next;
   ctrl_t  ctrl;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_FETCH;
      else          state <= state_next;
   end

   // Next-state and per-state control decode
   always_comb begin
      state_next = S_FETCH;
      ctrl       = '0;
      case (state)
         S_FETCH: begin
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            state_next     = S_DECODE;
         end
         S_DECODE: begin
            ctrl.alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXECUTE;
               OP_BEQ:       state_next = S_BRANCH;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JUMP;
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            state_next     = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            ctrl.iord  = 1'b1;
            state_next = S_MEMWB;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
            state_next     = S_ALUWB;
         end
         S_ALUWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.branch    = 1'b1;
            ctrl.pc_src    = 2'b01;
            ctrl.alu_op    = ALUOP_SUB;
         end
         S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            state_next     = S_ADDIWB;
         end
         S_ADDIWB: begin
            ctrl.reg_write = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = 2'b10;
         end
         default: state_next = S_FETCH;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (ctrl.alu_op),
      .funct       (funct),
      .alu_control (alu_control)
   );

   // Write enables are gated by reset so nothing commits while it is held
   assign ir_write   = reset_n & ctrl.ir_write;
   assign mem_write  = reset_n & ctrl.mem_write;
   assign reg_write  = reset_n & ctrl.reg_write;
   assign pc_en      = reset_n & (ctrl.pc_write | (ctrl.branch & zero_flag));
   assign iord       = ctrl.iord;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign pc_src     = ctrl.pc_src;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed and randomized
// instruction streams checked cycle by cycle against a per-instruction model.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       pc_en;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_control;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero_flag;
   logic       iord, mem_write, ir_write, pc_en, reg_dst, mem_to_reg;
   logic       reg_write, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;
   obs_t       obs;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .opcode      (opcode),
      .funct       (funct),
      .zero_flag   (zero_flag),
      .iord        (iord),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .pc_en       (pc_en),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .reg_write   (reg_write),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .pc_src      (pc_src),
      .alu_control (alu_control)
   );

   assign obs = {iord, mem_write, ir_write, pc_en, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, pc_src, alu_control};

   // Reference: number of cycles an instruction spends from FETCH to FETCH
   function automatic int instr_len(input logic [5:0] op);
      case (op)
         6'b100011:                       return 5;
         6'b101011, 6'b000000, 6'b001000: return 4;
         6'b000100, 6'b000010:            return 3;
         default:                         return 2;
      endcase
   endfunction

   function automatic logic [2:0] funct_op(input logic [5:0] fn);
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Reference: expected outputs in cycle k of an instruction
   function automatic obs_t model(input logic [5:0] op, input logic [5:0] fn,
                                  input int k, input logic z);
      obs_t e;
      e = '0;
      e.alu_control = 3'b010;
      if (k == 0) begin
         e.ir_write = 1'b1; e.pc_en = 1'b1; e.alu_src_b = 2'b01;
      end else if (k == 1) begin
         e.alu_src_b = 2'b11;
      end else begin
         case (op)
            6'b100011: begin
               if (k == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
               if (k == 3) e.iord = 1'b1;
               if (k == 4) begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            end
            6'b101011: begin
               if (k == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
               if (k == 3) begin e.iord = 1'b1; e.mem_write = 1'b1; end
            end
            6'b000000: begin
               if (k == 2) begin e.alu_src_a = 1'b1; e.alu_control = funct_op(fn); end
               if (k == 3) begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
            end
            6'b001000: begin
               if (k == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
               if (k == 3) e.reg_write = 1'b1;
            end
            6'b000100: begin
               e.alu_src_a = 1'b1; e.pc_src = 2'b01;
               e.alu_control = 3'b110; e.pc_en = z;
            end
            6'b000010: begin
               e.pc_en = 1'b1; e.pc_src = 2'b10;
            end
            default: ;
         endcase
      end
      return e;
   endfunction

   task automatic check(input string tag, input obs_t got, input obs_t want);
      checks++;
      assert (got === want)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // Runs one instruction starting just after a negedge in FETCH; zmode 2 = random zero
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int zmode, input string name);
      int n;
      n = instr_len(op);
      opcode = op;
      funct  = fn;
      for (int k = 0; k < n; k++) begin
         zero_flag = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         #1;
         check($sformatf("%s op=%b fn=%b cyc%0d", name, op, fn, k), obs,
               model(op, fn, k, zero_flag));
         @(negedge clk);
      end
   endtask

   obs_t reset_obs;
   logic [5:0] rt_fn [6];
   logic [5:0] op_pool [6];

   initial begin
      reset_obs = '0;
      reset_obs.alu_src_b   = 2'b01;
      reset_obs.alu_control = 3'b010;
      rt_fn   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      op_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

      reset_n = 1'b0; opcode = 6'b111111; funct = '0; zero_flag = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("reset_hold", obs, reset_obs);
      end
      reset_n = 1'b1;

      run_instr(6'b100011, 6'b000000, 0, "lw");
      foreach (rt_fn[i]) run_instr(6'b000000, rt_fn[i], 0, "rtype");
      run_instr(6'b000100, 6'b000000, 1, "beq_taken");
      run_instr(6'b000100, 6'b000000, 0, "beq_not_taken");
      run_instr(6'b000010, 6'b000000, 0, "j");
      run_instr(6'b111111, 6'b000000, 1, "unsupported");
      run_instr(6'b101011, 6'b000000, 1, "sw");
      run_instr(6'b001000, 6'b000000, 0, "addi");

      // sw interrupted by reset while in MEMWRITE
      opcode = 6'b101011;
      repeat (3) @(negedge clk);
      #1 check("sw_memwrite", obs, model(6'b101011, '0, 3, zero_flag));
      #1 reset_n = 1'b0;
      #1 check("midreset_async", obs, reset_obs);
      @(negedge clk);
      check("midreset_hold", obs, reset_obs);
      reset_n = 1'b1;
      run_instr(6'b100011, 6'b000000, 0, "after_reset_lw");

      for (int i = 0; i < 300; i++) begin
         logic [5:0] op;
         logic [5:0] fn;
         op = ($urandom_range(0, 7) < 6) ? op_pool[$urandom_range(0, 5)]
                                          : 6'($urandom_range(0, 63));
         fn = ($urandom_range(0, 3) != 0) ? rt_fn[$urandom_range(0, 5)]
                                           : 6'($urandom_range(0, 63));
         run_instr(op, fn, 2, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
